vpu_nrw_packer: RTL and testbench
=================================

VPU_NRW_PACKER -- requirements
Module: vpu_nrw_packer

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 16: width of one narrow input element.
REQ-002 SHALL have parameter OUT_WIDTH, default 32: width of the packed word written to the narrow-read FIFO.
REQ-003 SHALL have parameter CNT_WIDTH, default 16: width of the written-word counter.
REQ-004 SHALL require OUT_WIDTH/IN_WIDTH (RATIO) to be 1, 2 or 4 and OUT_WIDTH to be an exact multiple of IN_WIDTH; other values are unsupported.
REQ-005 clk  input  1  single clock; all state is updated on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous and active-low.
REQ-007 valid_i  input  1  upstream element valid.
REQ-008 data_i  input  IN_WIDTH  upstream element.
REQ-009 last_i  input  1  qualifies data_i; marks the final element of a burst.
REQ-010 ready_o  output  1  packer can accept an element this cycle.
REQ-011 wren_o  output  1  FIFO write enable, one word per asserted cycle.
REQ-012 wdata_o  output  OUT_WIDTH  packed word to FIFO.
REQ-013 wrfull_i  input  1  FIFO write-side full flag.
REQ-014 busy_o  output  1  partial word or pending word held.
REQ-015 words_o  output  CNT_WIDTH  count of words written since reset.

Function
REQ-016 SHALL accept an element on every rising edge where valid_i=1 and ready_o=1; otherwise data_i and last_i are ignored.
REQ-017 SHALL place the k-th accepted element of a word (k=0..RATIO-1) in bits [k*IN_WIDTH+IN_WIDTH-1 : k*IN_WIDTH]; element 0 is least significant.
REQ-018 SHALL keep an accumulator and an element index cnt (0..RATIO-1); each accept stores data_i at slot cnt and increments cnt.
REQ-019 SHALL complete a word when the accept is at cnt=RATIO-1 or carries last_i=1; on completion the word moves to a holding register, cnt returns to 0, and the accumulator clears.
REQ-020 SHALL zero-fill every slot not written when a word completes early on last_i.
REQ-021 SHALL implement a two-state output FSM: OUT_IDLE (holding register empty) and OUT_WAIT (holding register valid).
REQ-022 OUT_IDLE -> OUT_WAIT on word completion. OUT_WAIT -> OUT_IDLE on an edge with wren_o=1 and no new completion. OUT_WAIT -> OUT_WAIT otherwise, and the register reloads if wren_o=1 and a completion coincide.
REQ-023 SHALL drive wren_o = (state==OUT_WAIT) & !wrfull_i combinationally, so a word completed at edge N is written in cycle N+1 when the FIFO is not full.
REQ-024 SHALL drive wdata_o from the holding register; its value is meaningful only while wren_o=1.
REQ-025 SHALL drive ready_o = (state==OUT_IDLE) | !wrfull_i, with no dependency on valid_i.
REQ-026 SHALL never assert wren_o while wrfull_i=1; the word is held, unmodified, until wrfull_i=0.
REQ-027 SHALL sustain one accept per cycle with wrfull_i=0: one write every RATIO cycles, and no ready_o deassertion.
REQ-028 With RATIO=1, SHALL make every accept a completion; last_i has no extra effect.
REQ-029 SHALL increment words_o by 1 on each edge with wren_o=1, wrapping modulo 2^CNT_WIDTH.
REQ-030 SHALL drive busy_o = (cnt!=0) | (state==OUT_WAIT).

Reset
REQ-031 While rst_n=0, SHALL force: state=OUT_IDLE, cnt=0, accumulator=0, holding register=0, words_o=0, wren_o=0, busy_o=0, ready_o=1.
REQ-032 SHALL discard any partial or pending word on reset mid-operation, and SHALL resume at slot 0 after rst_n rises.

Verification
REQ-033 IN=16/OUT=32, wrfull_i=0, accept 0x1111 then 0x2222 on consecutive edges -> the next cycle has wren_o=1 and wdata_o=0x22221111, and words_o=1 after that edge.
REQ-034 IN=16/OUT=32, accept 0x000A, 0x000B, then 0x000C with last_i=1 -> two writes: 0x000B000A, then 0x0000000C.
REQ-035 Word pending and wrfull_i=1 for 5 cycles -> ready_o=0 and wren_o=0 throughout, with wdata_o stable. wrfull_i falls -> wren_o=1 and ready_o=1 in that same cycle.
REQ-036 IN=8/OUT=32, accept 0x01,0x02,0x03,0x04 -> a single write of 0x04030201, and busy_o=0 after the write.
REQ-037 IN=16/OUT=32, accept 0x5555, assert rst_n=0 for one cycle, release, then accept 0x1111 and 0x2222 -> the only write is 0x22221111, and words_o=1.
REQ-038 IN=16/OUT=32, valid_i=1 every cycle for 20 cycles with wrfull_i=0 -> ready_o stays 1, wren_o asserts every 2nd cycle, and words_o=10.

Source files
------------

// File: rtl/vpu_nrw_packer_if.sv
// Narrow-element upstream and packed-word
// FIFO-side signals of the packer.
interface vpu_nrw_packer_if #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 32
);
  logic                 valid_i;
  logic [IN_WIDTH-1:0]  data_i;
  logic                 last_i;
  logic                 ready_o;
  logic                 wren_o;
  logic [OUT_WIDTH-1:0] wdata_o;
  logic                 wrfull_i;

  modport master (
    output valid_i, data_i, last_i, wrfull_i,
    input  ready_o, wren_o, wdata_o
  );

  modport slave (
    input  valid_i, data_i, last_i, wrfull_i,
    output ready_o, wren_o, wdata_o
  );
endinterface

// File: rtl/vpu_nrw_packer.sv
// Packs RATIO narrow elements into one FIFO
// word; last_i flushes a zero-filled word.
module vpu_nrw_packer #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  vpu_nrw_packer_if.slave      bus,
  output logic                 busy_o,
  output logic [CNT_WIDTH-1:0] words_o
);

  localparam int RATIO = OUT_WIDTH / IN_WIDTH;
  localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;

  typedef enum logic [0:0] {
    OUT_IDLE,
    OUT_WAIT
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CW-1:0]        r_cnt;
  logic [OUT_WIDTH-1:0] r_acc;
  logic [OUT_WIDTH-1:0] r_hold;
  logic [CNT_WIDTH-1:0] r_words;
  logic [OUT_WIDTH-1:0] w_word;
  logic                 w_accept;
  logic                 w_done;
  logic                 w_wren;

  assign w_wren   = (r_state == OUT_WAIT) & ~bus.wrfull_i;
  assign w_accept = bus.valid_i & bus.ready_o;
  assign w_done   = w_accept &
                    ((r_cnt == CW'(RATIO - 1)) | bus.last_i);

  assign bus.ready_o = (r_state == OUT_IDLE) | ~bus.wrfull_i;
  assign bus.wren_o  = w_wren;
  assign bus.wdata_o = r_hold;
  assign busy_o      = (r_cnt != '0) | (r_state == OUT_WAIT);
  assign words_o     = r_words;

  // Merge the incoming element into its slot of the accumulator.
  always_comb begin
    w_word = r_acc;
    for (int k = 0; k < RATIO; k++) begin
      if (r_cnt == CW'(k))
        w_word[k*IN_WIDTH +: IN_WIDTH] = bus.data_i;
    end
  end

  // Accumulator, slot index and holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_acc  <= '0;
      r_hold <= '0;
    end else if (w_accept) begin
      if (w_done) begin
        r_cnt  <= '0;
        r_acc  <= '0;
        r_hold <= w_word;
      end else begin
        r_cnt  <= r_cnt + CW'(1);
        r_acc  <= w_word;
      end
    end
  end

  // Output FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= OUT_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Output FSM next-state: hold a word until the FIFO takes it.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      OUT_IDLE: if (w_done) w_state_nxt = OUT_WAIT;
      OUT_WAIT: if (w_wren && !w_done) w_state_nxt = OUT_IDLE;
      default:  w_state_nxt = OUT_IDLE;
    endcase
  end

  // Written-word counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_words <= '0;
    else if (w_wren) r_words <= r_words + CNT_WIDTH'(1);
  end

endmodule

// File: tb/tb_vpu_nrw_packer.sv
// Scoreboard bench for vpu_nrw_packer
// in 16->32 and 8->32 configurations.
module tb_vpu_nrw_packer;

  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;

  vpu_nrw_packer_if #(.IN_WIDTH(16), .OUT_WIDTH(32)) ia ();
  vpu_nrw_packer_if #(.IN_WIDTH(8),  .OUT_WIDTH(32)) ib ();

  logic        busy_a, busy_b;
  logic [15:0] words_a, words_b;

  vpu_nrw_packer #(.IN_WIDTH(16), .OUT_WIDTH(32), .CNT_WIDTH(16)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(ia), .busy_o(busy_a), .words_o(words_a)
  );
  vpu_nrw_packer #(.IN_WIDTH(8), .OUT_WIDTH(32), .CNT_WIDTH(16)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(ib), .busy_o(busy_b), .words_o(words_b)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  int exp_wa = 0;
  int exp_wb = 0;

  // Scoreboard for 16->32: every write must match the next expected word.
  always @(negedge clk) begin
    if (rst_n && ia.wren_o) begin
      logic [31:0] e;
      n_cmp++;
      if (ia.wrfull_i) begin
        n_bad++;
        $display("FAIL a_wren_while_full: wren=1 wrfull=1");
      end else if (qa.size() == 0) begin
        n_bad++;
        $display("FAIL a_unexpected_write: got %h, none expected", ia.wdata_o);
      end else begin
        e = qa.pop_front();
        if (ia.wdata_o !== e) begin
          n_bad++;
          $display("FAIL a_wdata: got %h want %h", ia.wdata_o, e);
        end
      end
      exp_wa++;
    end
  end

  // Scoreboard for 8->32.
  always @(negedge clk) begin
    if (rst_n && ib.wren_o) begin
      logic [31:0] e;
      n_cmp++;
      if (qb.size() == 0) begin
        n_bad++;
        $display("FAIL b_unexpected_write: got %h, none expected", ib.wdata_o);
      end else begin
        e = qb.pop_front();
        if (ib.wdata_o !== e) begin
          n_bad++;
          $display("FAIL b_wdata: got %h want %h", ib.wdata_o, e);
        end
      end
      exp_wb++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [15:0] d, input logic l);
    int t;
    ia.valid_i = 1;
    ia.data_i  = d;
    ia.last_i  = l;
    t = 0;
    while (!ia.ready_o && t < 50) begin
      tick();
      t++;
    end
    if (t == 50) begin
      n_cmp++;
      n_bad++;
      $display("FAIL a_ready_timeout: ready=0 want 1");
    end
    tick();
  endtask

  task automatic send_b(input logic [7:0] d, input logic l);
    int t;
    ib.valid_i = 1;
    ib.data_i  = d;
    ib.last_i  = l;
    t = 0;
    while (!ib.ready_o && t < 50) begin
      tick();
      t++;
    end
    if (t == 50) begin
      n_cmp++;
      n_bad++;
      $display("FAIL b_ready_timeout: ready=0 want 1");
    end
    tick();
  endtask

  task automatic idle();
    ia.valid_i = 0;
    ia.last_i  = 0;
    ib.valid_i = 0;
    ib.last_i  = 0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((qa.size() != 0 || qb.size() != 0) && t < 40) begin
      tick();
      t++;
    end
    n_cmp++;
    if (t == 40) begin
      n_bad++;
      $display("FAIL drain_timeout: pending a=%0d b=%0d want 0",
               qa.size(), qb.size());
    end
    tick();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 0;
    #1;
    qa.delete();
    qb.delete();
    exp_wa = 0;
    exp_wb = 0;
    tick();
    #1;
    rst_n = 1;
    tick();
  endtask

  task automatic test_reset();
    idle();
    ia.wrfull_i = 0;
    ib.wrfull_i = 0;
    ia.data_i = 0;
    ib.data_i = 0;
    rst_n = 0;
    #12;
    n_cmp += 5;
    if (ia.wren_o !== 1'b0) begin
      n_bad++; $display("FAIL rst_wren: got %b want 0", ia.wren_o);
    end
    if (busy_a !== 1'b0) begin
      n_bad++; $display("FAIL rst_busy: got %b want 0", busy_a);
    end
    if (ia.ready_o !== 1'b1) begin
      n_bad++; $display("FAIL rst_ready: got %b want 1", ia.ready_o);
    end
    if (words_a !== 16'd0) begin
      n_bad++; $display("FAIL rst_words: got %0d want 0", words_a);
    end
    if (ib.ready_o !== 1'b1 || busy_b !== 1'b0) begin
      n_bad++; $display("FAIL rst_b: ready=%b busy=%b want 1/0",
                        ib.ready_o, busy_b);
    end
    @(negedge clk);
    rst_n = 1;
    tick();
  endtask

  task automatic test_pair();
    qa.push_back(32'h2222_1111);
    send_a(16'h1111, 0);
    send_a(16'h2222, 0);
    idle();
    n_cmp += 3;
    if (ia.wren_o !== 1'b1) begin
      n_bad++; $display("FAIL pair_wren: got %b want 1", ia.wren_o);
    end
    if (ia.wdata_o !== 32'h2222_1111) begin
      n_bad++; $display("FAIL pair_wdata: got %h want 22221111", ia.wdata_o);
    end
    if (words_a !== 16'd0) begin
      n_bad++; $display("FAIL pair_words0: got %0d want 0", words_a);
    end
    tick();
    n_cmp++;
    if (words_a !== 16'd1) begin
      n_bad++; $display("FAIL pair_words1: got %0d want 1", words_a);
    end
    drain();
  endtask

  task automatic test_last();
    qa.push_back(32'h000B_000A);
    qa.push_back(32'h0000_000C);
    send_a(16'h000A, 0);
    send_a(16'h000B, 0);
    send_a(16'h000C, 1);
    idle();
    drain();
    n_cmp += 2;
    if (busy_a !== 1'b0) begin
      n_bad++; $display("FAIL last_busy: got %b want 0", busy_a);
    end
    if (words_a !== 16'(exp_wa)) begin
      n_bad++; $display("FAIL last_words: got %0d want %0d", words_a, exp_wa);
    end
  endtask

  task automatic test_full();
    ia.wrfull_i = 1;
    qa.push_back(32'h4444_3333);
    send_a(16'h3333, 0);
    send_a(16'h4444, 0);
    idle();
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (ia.ready_o !== 1'b0 || ia.wren_o !== 1'b0 ||
          ia.wdata_o !== 32'h4444_3333 || busy_a !== 1'b1) begin
        n_bad++;
        $display("FAIL full_hold%0d: ready=%b wren=%b wdata=%h busy=%b want 0/0/44443333/1",
                 i, ia.ready_o, ia.wren_o, ia.wdata_o, busy_a);
      end
      tick();
    end
    ia.wrfull_i = 0;
    #1;
    n_cmp++;
    if (ia.wren_o !== 1'b1 || ia.ready_o !== 1'b1) begin
      n_bad++;
      $display("FAIL full_release: wren=%b ready=%b want 1/1",
               ia.wren_o, ia.ready_o);
    end
    drain();
  endtask

  task automatic test_ratio4();
    qb.push_back(32'h0403_0201);
    send_b(8'h01, 0);
    send_b(8'h02, 0);
    send_b(8'h03, 0);
    send_b(8'h04, 0);
    idle();
    drain();
    n_cmp += 2;
    if (busy_b !== 1'b0) begin
      n_bad++; $display("FAIL r4_busy: got %b want 0", busy_b);
    end
    if (words_b !== 16'd1) begin
      n_bad++; $display("FAIL r4_words: got %0d want 1", words_b);
    end
  endtask

  task automatic test_reset_mid();
    send_a(16'h5555, 0);
    idle();
    n_cmp++;
    if (busy_a !== 1'b1) begin
      n_bad++; $display("FAIL mid_busy_before: got %b want 1", busy_a);
    end
    do_reset();
    n_cmp++;
    if (words_a !== 16'd0 || busy_a !== 1'b0) begin
      n_bad++; $display("FAIL mid_after_rst: words=%0d busy=%b want 0/0",
                        words_a, busy_a);
    end
    qa.push_back(32'h2222_1111);
    send_a(16'h1111, 0);
    send_a(16'h2222, 0);
    idle();
    drain();
    n_cmp++;
    if (words_a !== 16'd1) begin
      n_bad++; $display("FAIL mid_words: got %0d want 1", words_a);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int j = 0; j < 10; j++)
      qa.push_back({16'(16'h0100 + 2*j + 1), 16'(16'h0100 + 2*j)});
    for (int i = 0; i < 20; i++) begin
      ia.valid_i = 1;
      ia.data_i  = 16'(16'h0100 + i);
      ia.last_i  = 0;
      #1;
      n_cmp++;
      if (ia.ready_o !== 1'b1) begin
        n_bad++; $display("FAIL b2b_ready%0d: got %b want 1", i, ia.ready_o);
      end
      tick();
      n_cmp++;
      if (ia.wren_o !== logic'(i % 2)) begin
        n_bad++; $display("FAIL b2b_wren%0d: got %b want %0d",
                          i, ia.wren_o, i % 2);
      end
    end
    idle();
    drain();
    n_cmp++;
    if (words_a !== 16'd10) begin
      n_bad++; $display("FAIL b2b_words: got %0d want 10", words_a);
    end
  endtask

  initial begin
    test_reset();
    test_pair();
    test_last();
    test_full();
    test_ratio4();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
